// File: rtl/lfsr_pkg.sv
// lfsr_pkg: lock-up constant, reverse-tap derivation and default maximal tap masks.
package lfsr_pkg;
    localparam logic [3:0]  TAPS_4  = 4'b0011;
    localparam logic [7:0]  TAPS_8  = 8'h1D;
    localparam logic [15:0] TAPS_16 = 16'h100B;
    function automatic logic [31:0] lock_value(input int width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction
    // Reverse taps: drop bit 0 (the bit shifted out going up) and insert the fed-back MSB.
    function automatic logic [31:0] taps_down(input int width, input logic [31:0] taps);
        return (taps >> 1) | (32'd1 << (width - 1));
    endfunction
endpackage

// File: rtl/lfsr_updown_param_if.sv
// lfsr_updown_param_if: control inputs and registered status outputs of the up/down LFSR.
interface lfsr_updown_param_if #(parameter int WIDTH = 8);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] pos;
    logic             wrap;
    logic             lock_err;
    modport master (output enable, up_down, load, seed, input count, pos, wrap, lock_err);
    modport slave  (input enable, up_down, load, seed, output count, pos, wrap, lock_err);
endinterface

// File: rtl/lfsr_pos_counter.sv
// lfsr_pos_counter: modulo-(2^WIDTH-1) up/down index with synchronous clear and wrap pulse.
module lfsr_pos_counter
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             step,
    input  logic             up,
    output logic [WIDTH-1:0] pos,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(lock_value(WIDTH) - 32'd1);
    logic at_edge;
    assign at_edge = up ? pos == LAST : pos == '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pos  <= '0;
            wrap <= 1'b0;
        end else begin
            pos  <= clr ? '0 : !step ? pos : at_edge ? (up ? '0 : LAST) : up ? pos + WIDTH'(1) : pos - WIDTH'(1);
            wrap <= !clr && step && at_edge;
        end
endmodule

// File: rtl/lfsr_updown_param.sv
// lfsr_updown_param: reversible XNOR Fibonacci LFSR with seed load, lock-up recovery and position tracking.
module lfsr_updown_param
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8)
) (
    input logic                clk,
    input logic                reset,
    lfsr_updown_param_if.slave bus
);
    localparam logic [WIDTH-1:0] LOCK    = WIDTH'(lock_value(WIDTH));
    localparam logic [WIDTH-1:0] TAPS_DN = WIDTH'(taps_down(WIDTH, 32'(TAPS)));
    if (WIDTH < 3 || WIDTH > 32 || !TAPS[0]) begin : g_bad_param
        $error("lfsr_updown_param: WIDTH must be 3..32 and TAPS[0] must be set");
    end
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] step_nxt;
    logic             lock_err_q;
    logic             is_lock;
    logic             seed_bad;
    logic             clr;
    logic             step;
    assign is_lock  = count_q == LOCK;
    assign seed_bad = bus.seed == LOCK;
    assign clr      = bus.load || (is_lock && bus.enable);
    assign step     = bus.enable && !bus.load && !is_lock;
    assign step_nxt = bus.up_down ? {~^(count_q & TAPS), count_q[WIDTH-1:1]}
                                  : {count_q[WIDTH-2:0], ~^(count_q & TAPS_DN)};
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count_q    <= '0;
            lock_err_q <= 1'b0;
        end else begin
            count_q    <= bus.load ? (seed_bad ? '0 : bus.seed) : clr ? '0 : step ? step_nxt : count_q;
            lock_err_q <= bus.load ? seed_bad : is_lock && bus.enable;
        end
    assign bus.count    = count_q;
    assign bus.lock_err = lock_err_q;
    lfsr_pos_counter #(.WIDTH(WIDTH)) u_pos (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .step (step),
        .up   (bus.up_down),
        .pos  (bus.pos),
        .wrap (bus.wrap)
    );
endmodule

// File: tb/tb_lfsr_updown_param.sv
// tb_lfsr_updown_param: directed WIDTH=4 sequences plus randomized WIDTH=8 run against a reference model.
module tb_lfsr_updown_param;
    import lfsr_pkg::*;
    typedef struct {
        logic [31:0] count;
        logic [31:0] pos;
        logic        wrap;
        logic        err;
        string       name;
    } exp_t;
    logic clk = 1'b0;
    logic rst4_n = 1'b0;
    logic rst8_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t q4[$];
    exp_t q8[$];
    always #5 clk = ~clk;
    lfsr_updown_param_if #(.WIDTH(4)) bus4();
    lfsr_updown_param_if #(.WIDTH(8)) bus8();
    lfsr_updown_param #(.WIDTH(4), .TAPS(TAPS_4)) dut4 (.clk(clk), .reset(rst4_n), .bus(bus4));
    lfsr_updown_param dut8 (.clk(clk), .reset(rst8_n), .bus(bus8));

    // Forward step: new MSB is 1 when an even number of tapped bits are set.
    function automatic logic [31:0] m_up(input int w, input logic [31:0] taps, input logic [31:0] c);
        int ones = 0;
        for (int i = 0; i < w; i++) if (taps[i] && c[i]) ones++;
        return (c >> 1) | (32'(ones % 2 == 0) << (w - 1));
    endfunction
    // Reverse step: the predecessor whose forward step lands on c.
    function automatic logic [31:0] m_down(input int w, input logic [31:0] taps, input logic [31:0] c);
        logic [31:0] base;
        base = (c << 1) & ((32'd1 << w) - 32'd1);
        return (m_up(w, taps, base) == c) ? base : base | 32'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic cmp(input exp_t e, input logic [31:0] c, input logic [31:0] p, input logic w, input logic er);
        chk({e.name, ".count"}, c, e.count);
        chk({e.name, ".pos"}, p, e.pos);
        chk({e.name, ".wrap"}, 32'(w), 32'(e.wrap));
        chk({e.name, ".lock_err"}, 32'(er), 32'(e.err));
    endtask

    always @(posedge clk) begin
        #1;
        if (q4.size() > 0) cmp(q4.pop_front(), 32'(bus4.count), 32'(bus4.pos), bus4.wrap, bus4.lock_err);
        if (q8.size() > 0) cmp(q8.pop_front(), 32'(bus8.count), 32'(bus8.pos), bus8.wrap, bus8.lock_err);
    end

    task automatic drv4(input logic en, input logic ud, input logic ld, input logic [3:0] sd,
                        input logic [3:0] ec, input int ep, input logic ew, input logic ee, input string nm);
        @(negedge clk);
        bus4.enable = en; bus4.up_down = ud; bus4.load = ld; bus4.seed = sd;
        q4.push_back('{32'(ec), 32'(ep), ew, ee, nm});
    endtask

    logic [31:0] c4;
    logic [7:0]  mc;
    int          mp;
    logic        en, ud, ld, w, er;
    logic [7:0]  sd;

    initial begin
        bus4.enable = 1'b0; bus4.up_down = 1'b1; bus4.load = 1'b0; bus4.seed = '0;
        bus8.enable = 1'b0; bus8.up_down = 1'b1; bus8.load = 1'b0; bus8.seed = '0;
        repeat (2) @(posedge clk);
        #1;
        cmp('{32'd0, 32'd0, 1'b0, 1'b0, "reset4"}, 32'(bus4.count), 32'(bus4.pos), bus4.wrap, bus4.lock_err);
        cmp('{32'd0, 32'd0, 1'b0, 1'b0, "reset8"}, 32'(bus8.count), 32'(bus8.pos), bus8.wrap, bus8.lock_err);
        @(negedge clk);
        rst4_n = 1'b1; rst8_n = 1'b1;
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b1000, 1, 1'b0, 1'b0, "up1");
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b1100, 2, 1'b0, 1'b0, "up2");
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b1110, 3, 1'b0, 1'b0, "up3");
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b0111, 4, 1'b0, 1'b0, "up4");
        drv4(1'b1, 1'b0, 1'b0, 4'h0, 4'b1110, 3, 1'b0, 1'b0, "dn3");
        drv4(1'b1, 1'b0, 1'b0, 4'h0, 4'b1100, 2, 1'b0, 1'b0, "dn2");
        drv4(1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 1, 1'b0, 1'b0, "dn1");
        drv4(1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 0, 1'b0, 1'b0, "dn0");
        drv4(1'b1, 1'b0, 1'b0, 4'h0, 4'b0001, 14, 1'b1, 1'b0, "dn_wrap");
        drv4(1'b0, 1'b0, 1'b0, 4'h0, 4'b0001, 14, 1'b0, 1'b0, "hold");
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b0000, 0, 1'b1, 1'b0, "up_wrap");
        c4 = 0;
        for (int i = 1; i <= 15; i++) begin
            c4 = m_up(4, 32'(TAPS_4), c4);
            drv4(1'b1, 1'b1, 1'b0, 4'h0, c4[3:0], i % 15, i == 15, 1'b0, "period");
        end
        drv4(1'b1, 1'b1, 1'b1, 4'hF, 4'b0000, 0, 1'b0, 1'b1, "load_lock");
        drv4(1'b0, 1'b1, 1'b0, 4'h0, 4'b0000, 0, 1'b0, 1'b0, "load_lock_quiet");
        drv4(1'b1, 1'b1, 1'b1, 4'hA, 4'b1010, 0, 1'b0, 1'b0, "load_seed");
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b0101, 1, 1'b0, 1'b0, "after_load");
        drv4(1'b0, 1'b1, 1'b0, 4'h0, 4'b1111, 1, 1'b0, 1'b0, "lock_hold");
        force dut4.count_q = 4'b1111;
        #1 release dut4.count_q;
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b0000, 0, 1'b0, 1'b1, "lock_recover");
        drv4(1'b0, 1'b1, 1'b0, 4'h0, 4'b0000, 0, 1'b0, 1'b0, "lock_quiet");
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b1000, 1, 1'b0, 1'b0, "pre_rst1");
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b1100, 2, 1'b0, 1'b0, "pre_rst2");
        @(negedge clk);
        bus4.enable = 1'b1; bus4.load = 1'b1; bus4.seed = 4'h5;
        #2 rst4_n = 1'b0;
        #1 cmp('{32'd0, 32'd0, 1'b0, 1'b0, "async_rst"}, 32'(bus4.count), 32'(bus4.pos), bus4.wrap, bus4.lock_err);
        @(posedge clk);
        #2 cmp('{32'd0, 32'd0, 1'b0, 1'b0, "rst_discard"}, 32'(bus4.count), 32'(bus4.pos), bus4.wrap, bus4.lock_err);
        @(negedge clk);
        bus4.enable = 1'b0; bus4.load = 1'b0;
        rst4_n = 1'b1;
        drv4(1'b1, 1'b1, 1'b0, 4'h0, 4'b1000, 1, 1'b0, 1'b0, "post_rst");
        drv4(1'b0, 1'b1, 1'b0, 4'h0, 4'b1000, 1, 1'b0, 1'b0, "idle4");

        mc = 0; mp = 0;
        for (int n = 0; n < 10000; n++) begin
            if (n == 5000) begin
                @(negedge clk);
                bus8.enable = 1'b1; bus8.load = 1'b0;
                #2 rst8_n = 1'b0;
                #1 cmp('{32'd0, 32'd0, 1'b0, 1'b0, "rand_rst"}, 32'(bus8.count), 32'(bus8.pos), bus8.wrap, bus8.lock_err);
                @(negedge clk);
                bus8.enable = 1'b0;
                rst8_n = 1'b1;
                mc = 0; mp = 0;
            end
            ld = $urandom_range(0, 19) == 0;
            en = $urandom_range(0, 9) < 7;
            ud = 1'($urandom_range(0, 1));
            sd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            w = 1'b0; er = 1'b0;
            if (ld) begin
                er = sd == 8'hFF;
                mc = er ? 8'h00 : sd;
                mp = 0;
            end else if (mc == 8'hFF) begin
                if (en) begin mc = 0; mp = 0; er = 1'b1; end
            end else if (en && ud) begin
                mc = 8'(m_up(8, 32'(TAPS_8), 32'(mc)));
                w = mp == 254;
                mp = (mp + 1) % 255;
            end else if (en) begin
                mc = 8'(m_down(8, 32'(TAPS_8), 32'(mc)));
                w = mp == 0;
                mp = (mp + 254) % 255;
            end
            @(negedge clk);
            bus8.enable = en; bus8.up_down = ud; bus8.load = ld; bus8.seed = sd;
            q8.push_back('{32'(mc), 32'(mp), w, er, "rand"});
        end
        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(q4.size() + q8.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
